// File: rtl/seq_mul_bcd_pkg.sv
// Shared constants for the sequential multiply / BCD conversion block:
// FSM encodings, default widths and counter sizing helpers.
package seq_mul_bcd_pkg;

    localparam int OPW_DEF  = 4;
    localparam int NDIG_DEF = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_CONV = 2'd2;

    // Decimal digits needed to hold the largest value of a 'bits'-wide binary number.
    function automatic int bcd_digits(input int bits);
        int v;
        int n;
        v = (1 << bits) - 1;
        n = 0;
        while (v > 0) begin
            v = v / 10;
            n = n + 1;
        end
        return (n == 0) ? 1 : n;
    endfunction

    function automatic int cnt_w(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/seq_mul_bcd_if.sv
// START/BUSY/DONE handshake plus operands and BCD result between the
// operand source (master) and the multiplier/converter (slave).
interface seq_mul_bcd_if #(
    parameter int OPW  = 4,
    parameter int NDIG = 2
);
    logic                i_start;
    logic [OPW-1:0]      i_a;
    logic [OPW-1:0]      i_b;
    logic                o_busy;
    logic                o_done;
    logic [4*NDIG-1:0]   o_bcd;
    logic                o_ovf;

    modport slave (
        input  i_start, i_a, i_b,
        output o_busy, o_done, o_bcd, o_ovf
    );

    modport master (
        output i_start, i_a, i_b,
        input  o_busy, o_done, o_bcd, o_ovf
    );
endinterface

// File: rtl/seq_mul_bcd_dd_adjust.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 before the shift.
module seq_mul_bcd_dd_adjust (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
endmodule

// File: rtl/seq_mul_bcd.sv
// Sequential shift-add multiplier followed by double-dabble conversion; the
// packed BCD result (saturated at all-nines with OVF) feeds the 7-seg display.
module seq_mul_bcd
    import seq_mul_bcd_pkg::*;
#(
    parameter int OPW  = OPW_DEF,
    parameter int NDIG = NDIG_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    seq_mul_bcd_if.slave  bus
);
    localparam int PW   = 2 * OPW;
    localparam int SDIG = bcd_digits(PW);
    localparam int SW   = 4 * SDIG + PW;
    localparam int MCW  = cnt_w(OPW);
    localparam int CCW  = cnt_w(PW);
    localparam logic [MCW-1:0] MUL_LAST  = MCW'(OPW - 1);
    localparam logic [CCW-1:0] CONV_LOAD = CCW'(PW - 1);

    logic [1:0]          r_state;
    logic                r_busy;
    logic                r_done;
    logic [MCW-1:0]      r_mul_cnt;
    logic [CCW-1:0]      r_conv_cnt;
    logic [OPW-1:0]      r_a;
    logic [OPW-1:0]      r_b;
    logic [PW-1:0]       r_prod;
    logic [SW-1:0]       r_scr;
    logic [4*NDIG-1:0]   r_bcd;
    logic                r_ovf;

    logic [PW-1:0]       w_addend;
    logic [PW-1:0]       w_prod_nxt;
    logic [4*SDIG-1:0]   w_adj;
    logic [SW-1:0]       w_scr_nxt;
    logic [4*SDIG-1:0]   w_dig;
    logic [4*NDIG-1:0]   w_res_bcd;
    logic                w_res_ovf;

    assign w_addend   = r_b[r_mul_cnt] ? (PW'(r_a) << r_mul_cnt) : '0;
    assign w_prod_nxt = r_prod + w_addend;

    for (genvar d = 0; d < SDIG; d++) begin : g_adj
        seq_mul_bcd_dd_adjust u_adj (
            .i_digit (r_scr[PW + 4*d +: 4]),
            .o_digit (w_adj[4*d +: 4])
        );
    end

    assign w_scr_nxt = {w_adj[4*SDIG-2:0], r_scr[PW-1:0], 1'b0};
    // After the final shift the binary field is empty and w_dig holds the full decimal value.
    assign w_dig     = w_scr_nxt[SW-1:PW];

    if (SDIG > NDIG) begin : g_sat
        assign w_res_ovf = |w_dig[4*SDIG-1:4*NDIG];
        assign w_res_bcd = w_res_ovf ? {NDIG{4'h9}} : w_dig[4*NDIG-1:0];
    end else begin : g_nosat
        assign w_res_ovf = 1'b0;
        assign w_res_bcd = (4*NDIG)'(w_dig);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mul_cnt  <= '0;
            r_conv_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_state   <= S_MUL;
                        r_busy    <= 1'b1;
                        r_mul_cnt <= '0;
                    end
                end
                S_MUL: begin
                    if (r_mul_cnt == MUL_LAST) begin
                        r_state    <= S_CONV;
                        r_conv_cnt <= CONV_LOAD;
                    end else begin
                        r_mul_cnt <= r_mul_cnt + MCW'(1);
                    end
                end
                S_CONV: begin
                    if (r_conv_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_conv_cnt <= r_conv_cnt - CCW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
            r_scr  <= '0;
            r_bcd  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_a    <= bus.i_a;
                        r_b    <= bus.i_b;
                        r_prod <= '0;
                    end
                end
                S_MUL: begin
                    r_prod <= w_prod_nxt;
                    if (r_mul_cnt == MUL_LAST) begin
                        r_scr <= {{(4*SDIG){1'b0}}, w_prod_nxt};
                    end
                end
                S_CONV: begin
                    r_scr <= w_scr_nxt;
                    if (r_conv_cnt == '0) begin
                        r_bcd <= w_res_bcd;
                        r_ovf <= w_res_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_bcd  = r_bcd;
    assign bus.o_ovf  = r_ovf;

endmodule
